// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier: one partial-product step per clock,
// fixed WIDTH-cycle run time, product held between operations.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    mcand_next;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    acc_next;
  logic [WIDTH-1:0]    mq;
  logic [WIDTH-1:0]    mq_next;
  logic [PROD_W-1:0]   product_next;
  logic [WIDTH-1:0]    addend;
  logic [WIDTH:0]      sum;

  // Partial-product add; the carry becomes the MSB shifted into acc
  always_comb begin
    addend = mq[0] ? mcand : '0;
    sum    = {1'b0, acc} + {1'b0, addend};
  end

  // Next-state and datapath update
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    mcand_next   = mcand;
    acc_next     = acc;
    mq_next      = mq;
    product_next = product_o;

    case (state)
      IDLE, DONE: begin
        if (start_i) begin
          state_next = RUN;
          mcand_next = a_i;
          mq_next    = b_i;
          acc_next   = '0;
          cnt_next   = '0;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        acc_next = sum[WIDTH:1];
        mq_next  = {sum[0], mq[WIDTH-1:1]};
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_next   = DONE;
          product_next = {acc_next, mq_next};
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      acc       <= '0;
      mq        <= '0;
      product_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      mcand     <= mcand_next;
      acc       <= acc_next;
      mq        <= mq_next;
      product_o <= product_next;
      busy_o    <= (state_next == RUN);
      done_o    <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier with hand-computed products.
module tb_seq_multiplier;

  localparam int unsigned WIDTH = 32;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic               start_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] product_o;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one multiply and follow it to its done pulse.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    logic [63:0] prev;
    int          busy_cnt;
    int          cyc;
    bit          held;
    prev    = product_o;
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
    busy_cnt = 0;
    cyc      = 0;
    held     = 1'b1;
    while (!done_o && cyc < 100) begin
      if (busy_o) busy_cnt++;
      if (product_o !== prev) held = 1'b0;
      @(posedge clk_i); #1;
      cyc++;
    end
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_held"}, 64'(held), 64'd1);
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_busy_in_done"}, 64'(busy_o), 64'd0);
    check({tag, "_product"}, product_o, exp);
    @(posedge clk_i); #1;
    check({tag, "_done_drop"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [63:0] seen;

    rst_n_i = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    #12;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_product", product_o, 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    run_op("m3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    run_op("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("m0xb", 32'd0, 32'h1234_5678, 64'd0);
    run_op("m1xff", 32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
    run_op("m8000x2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    run_op("m10000sq", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

    // start during RUN is ignored
    start_i = 1'b1; a_i = 32'd7; b_i = 32'd9;
    @(posedge clk_i); #1;
    a_i = 32'd2; b_i = 32'd2;
    pulses = 0;
    seen   = '0;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) start_i = 1'b0;
      if (done_o) begin
        pulses++;
        seen = product_o;
      end
      @(posedge clk_i); #1;
    end
    check("ign_pulses", 64'(pulses), 64'd1);
    check("ign_product", seen, 64'h3F);
    check("ign_idle_busy", 64'(busy_o), 64'd0);

    // back-to-back accept from DONE
    start_i = 1'b1; a_i = 32'd3; b_i = 32'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 0;
    while (!done_o && cyc < 100) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("b2b_first_done", 64'(done_o), 64'd1);
    check("b2b_first_product", product_o, 64'hF);
    start_i = 1'b1; a_i = 32'd6; b_i = 32'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("b2b_no_idle", 64'(busy_o), 64'd1);
    cyc = 1;
    while (!done_o && cyc < 100) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("b2b_gap", 64'(cyc), 64'd33);
    check("b2b_product", product_o, 64'h2A);
    @(posedge clk_i); #1;

    // reset in the middle of RUN
    start_i = 1'b1; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2;
    check("midrst_busy_before", 64'(busy_o), 64'd1);
    rst_n_i = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_done", 64'(done_o), 64'd0);
    check("midrst_product", product_o, 64'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) pulses++;
    end
    check("midrst_quiet", 64'(pulses), 64'd0);
    check("midrst_product_held", product_o, 64'd0);

    // start honoured on the first edge after reset release
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #2;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_op("post_rst", 32'd12, 32'd13, 64'd156);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, setting the operand width in bits; legal values are 4 to 32 in steps of 4.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start_i, input, 1 bit: request to begin a multiply.
REQ-005 The block SHALL have port a_i, input, WIDTH bits: multiplicand, unsigned.
REQ-006 The block SHALL have port b_i, input, WIDTH bits: multiplier, unsigned.
REQ-007 The block SHALL have port busy_o, output, 1 bit: high while a multiply is in progress.
REQ-008 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when product_o is updated.
REQ-009 The block SHALL have port product_o, output, 2*WIDTH bits: the last completed unsigned product.

Function
REQ-010 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-011 In IDLE, start_i sampled high at an edge SHALL capture a_i and b_i, clear the iteration counter and the accumulator, and move the FSM to RUN.
REQ-012 In DONE, start_i sampled high SHALL behave as in IDLE (back-to-back accept), giving the same latency.
REQ-013 In RUN, start_i and changes on a_i or b_i SHALL be ignored; the captured operands govern the whole operation.
REQ-014 Each RUN cycle SHALL do one shift-add step on {carry, acc[WIDTH-1:0], mq[WIDTH-1:0]}, where mq initially holds the multiplier.
REQ-015 Shift-add step: if mq[0]=1, form {carry, acc} = acc + multiplicand (WIDTH+1-bit sum, carry kept); otherwise {carry, acc} = {0, acc}. Then shift {carry, acc, mq} right by one bit.
REQ-016 The addition SHALL be a plain WIDTH-bit unsigned ripple-carry add with carry-in 0; no carry SHALL be lost (the carry bit is the MSB shifted in).
REQ-017 RUN SHALL last exactly WIDTH cycles regardless of operand values, with no early exit on zero operands.
REQ-018 After the WIDTH-th RUN cycle, the FSM SHALL enter DONE and product_o SHALL load {acc, mq} on that same edge.
REQ-019 Latency: start accepted at edge k SHALL give done_o=1 and the new product_o in the cycle following edge k+WIDTH.
REQ-020 done_o SHALL be high only in DONE, for exactly one cycle per accepted start.
REQ-021 busy_o SHALL be high only in RUN.
REQ-022 product_o SHALL hold its value at all times except the DONE-entry edge; it does not change during RUN.
REQ-023 From DONE with start_i=0, the FSM SHALL return to IDLE on the next edge.
REQ-024 The result SHALL be bit-exact: product_o = a*b mod 2^(2*WIDTH), which is exact for unsigned inputs.
REQ-025 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within one operation.

Reset
REQ-026 Assertion of rst_n_i SHALL, without waiting for a clock edge, force: FSM to IDLE; busy_o=0; done_o=0; product_o=0; counter, accumulator, carry, mq and operand registers to 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done_o pulse SHALL follow the reset for that operation.
REQ-028 After deassertion of rst_n_i, start_i SHALL be honoured from the first rising edge.

Verification
REQ-029 Scenario: a=3, b=5, start pulse -> busy_o=1 for 32 cycles, then done_o=1 for one cycle and product_o=0x0000_0000_0000_000F.
REQ-030 Scenario: a=b=0xFFFF_FFFF -> product_o=0xFFFF_FFFE_0000_0001 (carry-out path exercised).
REQ-031 Scenario: a=0, b=0x1234_5678 -> still 32 busy cycles, then product_o=0; the previous product is held until done_o.
REQ-032 Scenario: start with 7x9, then start_i=1 with a=2, b=2 during RUN -> ignored; result is 0x3F and exactly one done_o pulse.
REQ-033 Scenario: start_i held high in DONE with a=6, b=7 -> next op accepted, no IDLE cycle; the second done_o comes 33 cycles after the first with product_o=0x2A.
REQ-034 Scenario: rst_n_i asserted at RUN cycle 10 -> outputs are 0 immediately, no done_o pulse; a new start after release gives a correct result.
